mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- Registered 4-input, WIDTH-bit data multiplexer with 2-bit select and a valid qualifier.
- Selects one of four data words and presents it on a registered output with 1-cycle latency.
- Sits in datapath steering logic wherever one of four same-width sources must be forwarded to a single sink on the system clock.

Parameters:
- WIDTH, 32, data width in bits of every data input and of o_data; legal range 1..1024.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_data0  input  WIDTH  source word 0, selected when i_sel = 2'd0.
- i_data1  input  WIDTH  source word 1, selected when i_sel = 2'd1.
- i_data2  input  WIDTH  source word 2, selected when i_sel = 2'd2.
- i_data3  input  WIDTH  source word 3, selected when i_sel = 2'd3.
- i_sel  input  2  select code.
- i_valid  input  1  qualifies i_sel and i_dataN for capture this cycle.
- o_data  output  WIDTH  registered selected word.
- o_sel  output  2  registered copy of the select code used for o_data.
- o_valid  output  1  high for the cycle after a captured i_valid.

Behaviour:
- Interface: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Reset: while i_rst_n = 0, the following hold regardless of the clock:
  - o_data = 0
  - o_sel = 2'd0
  - o_valid = 0
- Assertion of reset clears these outputs immediately, including mid-operation. Any in-flight word is discarded, not replayed.
- First capture occurs on the first rising i_clk edge with i_rst_n = 1.
- Capture (rising edge, i_valid = 1):
  - o_data <= i_data[i_sel], with 0->i_data0, 1->i_data1, 2->i_data2, 3->i_data3.
  - o_sel <= i_sel.
  - o_valid <= 1.
- Idle (rising edge, i_valid = 0):
  - o_valid <= 0.
  - o_data and o_sel hold their last captured values.
- Latency is exactly 1 cycle from input to output. No stall or backpressure; every i_valid cycle is accepted.
- Back-to-back i_valid cycles produce back-to-back o_valid with a new word each cycle.
- All four select codes are legal; there is no default or error path.
- Data is passed bit-exact; no width conversion, sign extension or arithmetic.
- Inputs are sampled only at the clock edge. Changes between edges have no effect on the outputs.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MUX_4TO1_PARITY_EN.
- With the macro defined:
  - Extra output port o_parity (1 bit) is present.
  - o_parity is the XOR-reduction (even-parity bit) of the word captured into o_data, registered in the same edge as o_data. It is therefore always consistent with the current o_data.
  - o_parity resets to 0 and holds when i_valid = 0.
- Without the macro:
  - Port o_parity and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold i_rst_n = 0 with i_data0..3 = 32'hFFFF_FFFF, i_valid = 1, toggling clock -> o_data = 0, o_sel = 0, o_valid = 0 throughout.
- Sweep select: i_data0..3 = 5, 17, 9, 31; i_valid = 1; i_sel = 0,1,2,3 on consecutive cycles -> one cycle later:
  - o_data = 5, 17, 9, 31
  - o_sel = 0,1,2,3
  - o_valid high for 4 consecutive cycles
- Hold: capture i_sel = 2 with i_data2 = 32'hDEAD_BEEF; then i_valid = 0 and i_data2 = 0 for 3 cycles -> o_data stays 32'hDEAD_BEEF, o_valid = 0 after the first cycle.
- Async reset mid-stream: during back-to-back valid traffic, drop i_rst_n between clock edges -> outputs go to 0 before the next edge; after release, first valid with i_sel = 1, i_data1 = 7 -> o_data = 7 one cycle later.
- Random: 10 cycles of random i_data0..3 in 0..31 and i_sel in 0..3 with i_valid = 1 -> each cycle o_data equals the selected input from the previous cycle. Checked by a scoreboard.
- With MUX_4TO1_PARITY_EN: capture 32'h0000_0007 -> o_parity = 1; capture 32'h0000_0003 -> o_parity = 0.

Source files
------------

// File: rtl/mux_4to1_if.sv
// Bus bundle for the registered 4:1 multiplexer: four source words, select and valid in, registered result out.
// Optional MUX_4TO1_PARITY_EN adds the o_parity result signal.
interface mux_4to1_if #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0] i_data0;
   logic [WIDTH-1:0] i_data1;
   logic [WIDTH-1:0] i_data2;
   logic [WIDTH-1:0] i_data3;
   logic [1:0]       i_sel;
   logic             i_valid;
   logic [WIDTH-1:0] o_data;
   logic [1:0]       o_sel;
   logic             o_valid;
`ifdef MUX_4TO1_PARITY_EN
   logic             o_parity;
`endif

`ifdef MUX_4TO1_PARITY_EN
   modport master (
      output i_data0, i_data1, i_data2, i_data3, i_sel, i_valid,
      input  o_data, o_sel, o_valid, o_parity
   );
   modport slave (
      input  i_data0, i_data1, i_data2, i_data3, i_sel, i_valid,
      output o_data, o_sel, o_valid, o_parity
   );
`else
   modport master (
      output i_data0, i_data1, i_data2, i_data3, i_sel, i_valid,
      input  o_data, o_sel, o_valid
   );
   modport slave (
      input  i_data0, i_data1, i_data2, i_data3, i_sel, i_valid,
      output o_data, o_sel, o_valid
   );
`endif
endinterface

// File: rtl/mux_4to1.sv
// Registered 4-input WIDTH-bit multiplexer with valid qualifier and 1-cycle latency.
// Define MUX_4TO1_PARITY_EN to add a registered even-parity bit of the captured word.
module mux_4to1 #(
   parameter int WIDTH = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   mux_4to1_if.slave  bus
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [1:0]       sel_q;
   logic [1:0]       sel_d;
   logic             valid_q;
   logic             valid_d;
`ifdef MUX_4TO1_PARITY_EN
   logic             parity_q;
   logic             parity_d;
`endif

   function automatic logic [WIDTH-1:0] pick_word(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] d0,
      input logic [WIDTH-1:0] d1,
      input logic [WIDTH-1:0] d2,
      input logic [WIDTH-1:0] d3
   );
      logic [WIDTH-1:0] w;
      case (sel)
         2'd0:    w = d0;
         2'd1:    w = d1;
         2'd2:    w = d2;
         2'd3:    w = d3;
         default: w = {WIDTH{1'b0}};
      endcase
      return w;
   endfunction

`ifdef MUX_4TO1_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction
`endif

   // Next-state: capture selected word on valid, otherwise hold data/sel and drop valid.
   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = 1'b0;
`ifdef MUX_4TO1_PARITY_EN
      parity_d = parity_q;
`endif
      if (bus.i_valid) begin
         data_d  = pick_word(bus.i_sel, bus.i_data0, bus.i_data1, bus.i_data2, bus.i_data3);
         sel_d   = bus.i_sel;
         valid_d = 1'b1;
`ifdef MUX_4TO1_PARITY_EN
         parity_d = even_parity(data_d);
`endif
      end else begin
         valid_d = 1'b0;
      end
   end

   // Output registers; reset clears them at once and discards any in-flight word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q  <= {WIDTH{1'b0}};
         sel_q   <= 2'd0;
         valid_q <= 1'b0;
`ifdef MUX_4TO1_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
`ifdef MUX_4TO1_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.o_data  = data_q;
   assign bus.o_sel   = sel_q;
   assign bus.o_valid = valid_q;
`ifdef MUX_4TO1_PARITY_EN
   assign bus.o_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed/table-driven bench for mux_4to1: reset, select sweep, hold, async reset, random scoreboard.
// Parity checks are compiled in when MUX_4TO1_PARITY_EN is defined.
module tb_mux_4to1;

   localparam int WIDTH = 32;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   mux_4to1_if #(.WIDTH(WIDTH)) bus ();

   mux_4to1 #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       sel;
      logic             valid;
      logic [WIDTH-1:0] d0;
      logic [WIDTH-1:0] d1;
      logic [WIDTH-1:0] d2;
      logic [WIDTH-1:0] d3;
      logic [WIDTH-1:0] exp_data;
      logic [1:0]       exp_sel;
      logic             exp_valid;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] sel, input logic valid, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
      bus.i_sel   = sel;
      bus.i_valid = valid;
      bus.i_data0 = d0;
      bus.i_data1 = d1;
      bus.i_data2 = d2;
      bus.i_data3 = d3;
   endtask

   task automatic check_out(input string name, input logic [WIDTH-1:0] ed, input logic [1:0] es, input logic ev);
      check({name, ".data"}, bus.o_data, ed);
      check({name, ".sel"}, {{(WIDTH-2){1'b0}}, bus.o_sel}, {{(WIDTH-2){1'b0}}, es});
      check({name, ".valid"}, {{(WIDTH-1){1'b0}}, bus.o_valid}, {{(WIDTH-1){1'b0}}, ev});
   endtask

   initial begin
      logic [WIDTH-1:0] r0, r1, r2, r3, exp_w;
      logic [1:0]       rs;
      n_vec = 0;
      n_bad = 0;

      // Sweep then hold: o_data/o_sel must keep the last capture while valid is low.
      vecs[0] = '{2'd0, 1'b1, 32'd5, 32'd17, 32'd9, 32'd31, 32'd5,  2'd0, 1'b1};
      vecs[1] = '{2'd1, 1'b1, 32'd5, 32'd17, 32'd9, 32'd31, 32'd17, 2'd1, 1'b1};
      vecs[2] = '{2'd2, 1'b1, 32'd5, 32'd17, 32'd9, 32'd31, 32'd9,  2'd2, 1'b1};
      vecs[3] = '{2'd3, 1'b1, 32'd5, 32'd17, 32'd9, 32'd31, 32'd31, 2'd3, 1'b1};
      vecs[4] = '{2'd2, 1'b1, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 2'd2, 1'b1};
      vecs[5] = '{2'd2, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF, 2'd2, 1'b0};
      vecs[6] = '{2'd2, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF, 2'd2, 1'b0};
      vecs[7] = '{2'd1, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'hDEAD_BEEF, 2'd2, 1'b0};
      vecs[8] = '{2'd3, 1'b1, 32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 1'b1};
      vecs[9] = '{2'd0, 1'b1, 32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0001, 2'd0, 1'b1};

      rst_n = 1'b0;
      drive(2'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_out("reset", 32'd0, 2'd0, 1'b0);
`ifdef MUX_4TO1_PARITY_EN
         check("reset.parity", {{(WIDTH-1){1'b0}}, bus.o_parity}, 32'd0);
`endif
      end

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].sel, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
         @(posedge clk);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_sel, vecs[i].exp_valid);
         @(negedge clk);
      end

      // Inputs changing between edges must not reach the outputs.
      drive(2'd1, 1'b1, 32'd0, 32'h1234, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      drive(2'd2, 1'b1, 32'd0, 32'd0, 32'h5555, 32'd0);
      #2;
      check_out("between_edges", 32'h1234, 2'd1, 1'b1);

      // Async reset dropped mid-cycle during back-to-back traffic.
      @(posedge clk);
      #1;
      check_out("pre_rst", 32'h5555, 2'd2, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 32'd0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'd1, 1'b1, 32'd0, 32'd7, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check_out("post_rst", 32'd7, 2'd1, 1'b1);

      // Random scoreboard: expected word is the selected input of the same capture edge.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         r0 = WIDTH'($urandom_range(31, 0));
         r1 = WIDTH'($urandom_range(31, 0));
         r2 = WIDTH'($urandom_range(31, 0));
         r3 = WIDTH'($urandom_range(31, 0));
         rs = 2'($urandom_range(3, 0));
         exp_w = (rs == 2'd0) ? r0 : (rs == 2'd1) ? r1 : (rs == 2'd2) ? r2 : r3;
         drive(rs, 1'b1, r0, r1, r2, r3);
         @(posedge clk);
         #1;
         check_out($sformatf("rand%0d", i), exp_w, rs, 1'b1);
      end

`ifdef MUX_4TO1_PARITY_EN
      @(negedge clk);
      drive(2'd0, 1'b1, 32'h0000_0007, 32'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check("parity7", {{(WIDTH-1){1'b0}}, bus.o_parity}, 32'd1);
      @(negedge clk);
      drive(2'd3, 1'b1, 32'd0, 32'd0, 32'd0, 32'h0000_0003);
      @(posedge clk);
      #1;
      check("parity3", {{(WIDTH-1){1'b0}}, bus.o_parity}, 32'd0);
      @(negedge clk);
      drive(2'd0, 1'b1, 32'h0000_0001, 32'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      drive(2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check("parity_hold", {{(WIDTH-1){1'b0}}, bus.o_parity}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
